// File: rtl/pseudo_datapath_if.sv
// Control/data bus between the micro-sequencer side and the execution datapath.
// The master (sequencer / environment) drives the control word and the external
// input word; the slave (datapath) returns the condition bit, the input
// acknowledge and the output word with its valid pulse.
interface pseudo_datapath_if #(
  parameter int P_DATA_WIDTH     = 8,
  parameter int P_NUM_D_CTRLBITS = 5
);

  // Control word: [4:2] opcode, [1:0] condition select
  logic [P_NUM_D_CTRLBITS-1:0] dp_ctrl;
  // Selected condition bit back to the sequencer
  logic                        cres;
  // External data input handshake
  logic [P_DATA_WIDTH-1:0]     din;
  logic                        din_valid;
  logic                        din_ack;
  // External data output
  logic [P_DATA_WIDTH-1:0]     dout;
  logic                        dout_valid;

  modport master (
    output dp_ctrl,
    output din,
    output din_valid,
    input  cres,
    input  din_ack,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  dp_ctrl,
    input  din,
    input  din_valid,
    output cres,
    output din_ack,
    output dout,
    output dout_valid
  );

endinterface

// File: rtl/pseudo_datapath.sv
// Execution datapath behind the micro-sequencer. Executes one micro-operation
// per clock on an accumulator/operand pair, keeps Z/C/N flags, and returns a
// single selected condition bit for conditional jumps. Also owns the CPU's
// external data input (valid/ack) and data output (one-cycle valid pulse).
//
// The condition bit is a pure mux of registered flags (plus din_valid), so a
// jump on an ALU result must be placed in the control word after that op.
// The field layout of the control word is fixed: P_NUM_D_CTRLBITS must be 5.
module pseudo_datapath #(
  parameter int P_DATA_WIDTH     = 8,
  parameter int P_NUM_D_CTRLBITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  pseudo_datapath_if.slave    bus
);

  localparam int W = P_DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDA = 3'b001,
    OP_LDB = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_DEC = 3'b101,
    OP_OUT = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    SEL_Z     = 2'b00,
    SEL_C     = 2'b01,
    SEL_N     = 2'b10,
    SEL_VALID = 2'b11
  } sel_e;

  // ---------------------------------------------------------------------------
  // Control word decode
  // ---------------------------------------------------------------------------
  op_e  op;
  sel_e sel;

  assign op  = op_e'(bus.dp_ctrl[4:2]);
  assign sel = sel_e'(bus.dp_ctrl[1:0]);

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] b_q, b_d;
  logic         z_q, z_d;
  logic         c_q, c_d;
  logic         n_q, n_d;
  logic [W-1:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;

  // ---------------------------------------------------------------------------
  // Arithmetic units (always computed; the opcode picks which one commits)
  // ---------------------------------------------------------------------------
  // Add at W+1 bits so the top bit is the carry out.
  logic [W:0]   add_res;
  // Subtract at W+1 bits; since both operands are below 2^W the top bit is set
  // exactly when acc < b, i.e. it is the unsigned borrow.
  logic [W:0]   sub_res;
  // Decrement wraps 0 -> all ones; that wrap is reported as a borrow in C.
  logic [W-1:0] dec_res;
  logic         acc_is_zero;

  assign add_res     = {1'b0, acc_q} + {1'b0, b_q};
  assign sub_res     = {1'b0, acc_q} - {1'b0, b_q};
  assign dec_res     = acc_q - {{(W-1){1'b0}}, 1'b1};
  assign acc_is_zero = (acc_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state selection for every register, one opcode per cycle
  // ---------------------------------------------------------------------------
  // Compute the post-op value of every state register from the current opcode.
  always_comb begin
    acc_d        = acc_q;
    b_d          = b_q;
    z_d          = z_q;
    c_d          = c_q;
    n_d          = n_q;
    dout_d       = dout_q;
    // The output pulse only survives into the cycle right after an OUT.
    dout_valid_d = 1'b0;

    unique case (op)
      OP_NOP: begin
      end

      // Loads take din whether or not it is valid; microcode is expected to
      // poll the valid condition first. Only the acknowledge depends on it.
      OP_LDA: begin
        acc_d = bus.din;
        z_d   = (bus.din == '0);
        n_d   = bus.din[W-1];
      end

      OP_LDB: begin
        b_d = bus.din;
      end

      OP_ADD: begin
        acc_d = add_res[W-1:0];
        c_d   = add_res[W];
        z_d   = (add_res[W-1:0] == '0);
        n_d   = add_res[W-1];
      end

      OP_SUB: begin
        acc_d = sub_res[W-1:0];
        c_d   = sub_res[W];
        z_d   = (sub_res[W-1:0] == '0);
        n_d   = sub_res[W-1];
      end

      OP_DEC: begin
        acc_d = dec_res;
        c_d   = acc_is_zero;
        z_d   = (dec_res == '0);
        n_d   = dec_res[W-1];
      end

      OP_OUT: begin
        dout_d       = acc_q;
        dout_valid_d = 1'b1;
      end

      // Compare: flags exactly as SUB, accumulator left untouched.
      OP_CMP: begin
        c_d = sub_res[W];
        z_d = (sub_res[W-1:0] == '0);
        n_d = sub_res[W-1];
      end

      default: begin
      end
    endcase
  end

  // Commit next state; asynchronous reset clears everything, including any
  // output pulse in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      b_q          <= '0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      n_q          <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      b_q          <= b_d;
      z_q          <= z_d;
      c_q          <= c_d;
      n_q          <= n_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic cres_sel;

  // Condition mux: registered flags only, never the flags of the op in flight.
  always_comb begin
    cres_sel = 1'b0;
    unique case (sel)
      SEL_Z:     cres_sel = z_q;
      SEL_C:     cres_sel = c_q;
      SEL_N:     cres_sel = n_q;
      SEL_VALID: cres_sel = bus.din_valid;
      default:   cres_sel = 1'b0;
    endcase
  end

  assign bus.cres       = cres_sel;
  // Acknowledge only when a load actually consumes a valid word.
  assign bus.din_ack    = ((op == OP_LDA) || (op == OP_LDB)) && bus.din_valid;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: doc/pseudo_datapath.md
Name: pseudo_datapath

Overview:
- Execution datapath on the far side of the micro-sequencer's control interface.
- Consumes the 5-bit per-cycle control word dp_ctrl and executes one micro-operation per clock on an accumulator/operand register pair.
- Returns the single condition bit cres, which the sequencer samples for conditional jumps.
- Also provides the external data input (valid/ack) and data output (valid pulse) of the CPU.

Parameters:
- P_DATA_WIDTH, 8, width of acc, b, din, dout.
- P_NUM_D_CTRLBITS, 5, width of dp_ctrl; the field layout below is fixed and requires 5.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- dp_ctrl  input  5  control word: [4:2] opcode, [1:0] condition select.
- cres  output  1  selected condition bit, combinational from registered state.
- din  input  P_DATA_WIDTH  external input data.
- din_valid  input  1  din holds a valid word.
- din_ack  output  1  combinational; high in the cycle din is consumed.
- dout  output  P_DATA_WIDTH  registered output data.
- dout_valid  output  1  registered; one-cycle pulse when dout updates.

Behaviour:
- State: acc[W-1:0], b[W-1:0], flags Z, C, N, dout, dout_valid.
- Async reset: all of the above go to 0. cres = selected flag, so 0 for every select except 11, which follows din_valid.
- Opcodes execute at the posedge ending the cycle in which they are presented:
  - 000 NOP: no state change.
  - 001 LDA: acc<=din; Z<=(din==0); N<=din[W-1]; C unchanged.
  - 010 LDB: b<=din; flags unchanged.
  - 011 ADD: {C,acc}<=acc+b computed at W+1 bits; Z and N taken from the W-bit result.
  - 100 SUB: acc<=acc-b mod 2^W; C<=borrow (1 iff acc<b unsigned); Z, N from the result.
  - 101 DEC: acc<=acc-1 mod 2^W; C<=1 iff acc==0 (wraps to all ones); Z, N from the result.
  - 110 OUT: dout<=acc; dout_valid<=1 for exactly the following cycle. Flags unchanged.
  - 111 CMP: computes acc-b as SUB does and updates Z, N, C; acc unchanged.
- dout_valid is 0 in any cycle not directly following an OUT. Back-to-back OUTs hold it high for consecutive cycles, each carrying the acc value of its own cycle.
- din_ack = (opcode==LDA or LDB) and din_valid.
- LDA/LDB with din_valid=0:
  - the destination register still loads din;
  - din_ack stays 0;
  - flag update rules still apply.
  - Microcode must poll select 11 before loading.
- Condition select dp_ctrl[1:0]: 00 Z, 01 C, 10 N, 11 din_valid.
  - cres is purely combinational: mux of registered flags / din_valid, with no dependency on the opcode in the same cycle.
  - Consequence: a jump conditioned on an ALU op's flags must sit in the word after that op. The word carrying the ALU op sees the pre-op flags.
- Reset mid-operation: async reset overrides any in-flight op. dout_valid drops immediately. No partial update survives.
- All arithmetic is unsigned modulo 2^W. N is simply the result MSB.

Test Plan:
- Reset, then select 00: cres=0; acc=b=dout=0; dout_valid=0. Select 11 with din_valid=1: cres=1.
- LDA din=0x05 (din_valid=1), LDB din=0x03, ADD, OUT:
  - din_ack high in both load cycles;
  - acc=0x08, Z=0, C=0;
  - dout=0x08 with dout_valid high for one cycle only.
- Carry/borrow wrap cases, W=8:
  - acc=0xFF, b=0x01, ADD -> acc=0x00, Z=1, C=1; select 00 next cycle gives cres=1.
  - acc=0x00, DEC -> acc=0xFF, C=1, N=1.
- CMP with acc=0x03, b=0x05 -> acc stays 0x03; C=1 (borrow), Z=0, N=1 (0xFE MSB). Repeat with b=0x03 -> Z=1, C=0.
- Countdown loop: acc=3, repeated DEC with select 00 in the following word -> cres goes 0,0,1 over the three decrements.
- Edge/handshake cases:
  - LDA with din_valid=0 -> din_ack=0 and acc=din.
  - Two consecutive OUTs with an ADD between values -> dout_valid high two cycles, each dout matching.
  - Assert rst while dout_valid=1 -> dout_valid=0 immediately and all state returns to 0.
